mem_bus_ctrl: RTL and testbench

// Memory-side bus controller sitting directly upstream of the 16-bit unified memory.

---
 rtl/mem_bus_ctrl_pkg.sv | 23 ++
 rtl/mem_bus_ctrl_arb.sv | 37 +++
 rtl/mem_bus_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_bus_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and defaults for the memory-side bus controller.
// Sequencer states, requester source codes and width defaults.
package mem_bus_ctrl_pkg;

  localparam int AW_DEF         = 16;
  localparam int DW_DEF         = 16;
  localparam int STARVE_MAX_DEF = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ACC    = 3'd1,
    RD_RESP   = 3'd2,
    WR_SETUP  = 3'd3,
    WR_PULSE  = 3'd4,
    WR_HOLD   = 3'd5
  } state_t;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_LS = 1'b1
  } src_t;

endpackage

// File: rtl/mem_bus_ctrl_arb.sv
// Fetch vs load/store arbiter with a starvation counter that forces a fetch
// grant after STARVE_MAX consecutive load/store grants taken while fetch waits.
module mem_bus_ctrl_arb #(
  parameter int STARVE_MAX = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic arb_en,
  input  logic if_req,
  input  logic ls_req,
  output logic grant_if,
  output logic grant_ls
);

  localparam int CW = $clog2(STARVE_MAX + 2);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == CW'(STARVE_MAX));

  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (arb_en) begin
      if (ls_req && !(if_req && starved)) grant_ls = 1'b1;
      else if (if_req)                    grant_if = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST)                     starve_cnt <= '0;
    else if (!if_req || grant_if) starve_cnt <= '0;
    else if (grant_ls && !starved) starve_cnt <= starve_cnt + 1'b1;
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: arbitrates fetch and load/store ports and sequences
// ADDR/WDBUS/RD/WR with one setup and one hold cycle around the write strobe.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IF_REQ,
  input  logic [AW-1:0] IF_ADDR,
  output logic          IF_GNT,
  output logic          IF_VALID,
  output logic [DW-1:0] IF_DATA,
  input  logic          LS_REQ,
  input  logic          LS_WE,
  input  logic [AW-1:0] LS_ADDR,
  input  logic [DW-1:0] LS_WDATA,
  output logic          LS_GNT,
  output logic          LS_VALID,
  output logic [DW-1:0] LS_RDATA,
  output logic [AW-1:0] ADDR,
  output logic [DW-1:0] WDBUS,
  output logic          RD,
  output logic          WR,
  input  logic [DW-1:0] RDBUS
);

  state_t state, state_nxt;
  src_t   src_q;
  logic   grant_if, grant_ls;
  logic   if_gnt_d, ls_gnt_d, rd_d, wr_d, if_valid_d, ls_valid_d;

  mem_bus_ctrl_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .CLK      (CLK),
    .RST      (RST),
    .arb_en   (state == IDLE),
    .if_req   (IF_REQ),
    .ls_req   (LS_REQ),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  // Outputs are registered, so each pin reflects the state just left.
  always_comb begin
    state_nxt  = state;
    if_gnt_d   = 1'b0;
    ls_gnt_d   = 1'b0;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    if_valid_d = 1'b0;
    ls_valid_d = 1'b0;
    case (state)
      IDLE: begin
        if (grant_if) begin
          if_gnt_d  = 1'b1;
          state_nxt = RD_ACC;
        end else if (grant_ls) begin
          ls_gnt_d  = 1'b1;
          state_nxt = LS_WE ? WR_SETUP : RD_ACC;
        end
      end
      RD_ACC: begin
        rd_d      = 1'b1;
        state_nxt = RD_RESP;
      end
      RD_RESP: begin
        if (src_q == SRC_IF) if_valid_d = 1'b1;
        else                 ls_valid_d = 1'b1;
        state_nxt = IDLE;
      end
      WR_SETUP: state_nxt = WR_PULSE;
      WR_PULSE: begin
        wr_d      = 1'b1;
        state_nxt = WR_HOLD;
      end
      WR_HOLD: begin
        ls_valid_d = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      src_q    <= SRC_IF;
      ADDR     <= '0;
      WDBUS    <= '0;
      RD       <= 1'b0;
      WR       <= 1'b0;
      IF_GNT   <= 1'b0;
      LS_GNT   <= 1'b0;
      IF_VALID <= 1'b0;
      LS_VALID <= 1'b0;
      IF_DATA  <= '0;
      LS_RDATA <= '0;
    end else begin
      state    <= state_nxt;
      RD       <= rd_d;
      WR       <= wr_d;
      IF_GNT   <= if_gnt_d;
      LS_GNT   <= ls_gnt_d;
      IF_VALID <= if_valid_d;
      LS_VALID <= ls_valid_d;
      if (grant_if) begin
        ADDR  <= IF_ADDR;
        src_q <= SRC_IF;
      end else if (grant_ls) begin
        ADDR  <= LS_ADDR;
        src_q <= SRC_LS;
        if (LS_WE) WDBUS <= LS_WDATA;
      end
      // RD is high throughout RD_RESP, so RDBUS is settled at this edge.
      if (state == RD_RESP) begin
        if (src_q == SRC_IF) IF_DATA  <= RDBUS;
        else                 LS_RDATA <= RDBUS;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed + randomized bench for mem_bus_ctrl with a memory model and a
// reference image of memory contents used to predict every returned word.
module tb_mem_bus_ctrl;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int SMAX = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          IF_REQ, LS_REQ, LS_WE;
  logic [AW-1:0] IF_ADDR, LS_ADDR;
  logic [DW-1:0] LS_WDATA;
  logic          IF_GNT, IF_VALID, LS_GNT, LS_VALID, RD, WR;
  logic [DW-1:0] IF_DATA, LS_RDATA, WDBUS, RDBUS;
  logic [AW-1:0] ADDR;

  mem_bus_ctrl #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .RST(RST),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT), .IF_VALID(IF_VALID), .IF_DATA(IF_DATA),
    .LS_REQ(LS_REQ), .LS_WE(LS_WE), .LS_ADDR(LS_ADDR), .LS_WDATA(LS_WDATA),
    .LS_GNT(LS_GNT), .LS_VALID(LS_VALID), .LS_RDATA(LS_RDATA),
    .ADDR(ADDR), .WDBUS(WDBUS), .RD(RD), .WR(WR), .RDBUS(RDBUS)
  );

  always #5 CLK = ~CLK;

  // Memory device model and the bench's own expected-contents image.
  logic [DW-1:0] mem     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];
  assign RDBUS = RD ? mem[ADDR] : '0;
  always @(posedge CLK) if (WR) mem[ADDR] <= WDBUS;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  // Load or store on the LS port; assumes the controller is idle on entry.
  task automatic do_ls(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    LS_REQ = 1'b1; LS_WE = we; LS_ADDR = a; LS_WDATA = d;
    do begin tick(); n++; end while (!LS_GNT && n < 20);
    chk("ls_gnt_latency", n, 1);
    LS_REQ = 1'b0;
    if (!LS_GNT) return;
    chk("ls_n_addr", ADDR, a);
    chk("ls_n_rdwr", {RD, WR}, 2'b00);
    if (we) begin
      tick();
      chk("st_setup_wr", WR, 0);
      chk("st_setup_addr", ADDR, a);
      chk("st_setup_wd", WDBUS, d);
      chk("st_setup_valid", LS_VALID, 0);
      tick();
      chk("st_pulse_wr", WR, 1);
      chk("st_pulse_rd", RD, 0);
      chk("st_pulse_addr", ADDR, a);
      chk("st_pulse_wd", WDBUS, d);
      ref_mem[a] = d;
      tick();
      chk("st_hold_wr", WR, 0);
      chk("st_hold_addr", ADDR, a);
      chk("st_hold_valid", LS_VALID, 1);
    end else begin
      tick();
      chk("ld_acc_rd", RD, 1);
      chk("ld_acc_addr", ADDR, a);
      chk("ld_acc_valid", LS_VALID, 0);
      tick();
      chk("ld_resp_rd", RD, 0);
      chk("ld_resp_valid", LS_VALID, 1);
      chk("ld_resp_data", LS_RDATA, ref_mem[a]);
    end
  endtask

  task automatic do_if(input logic [AW-1:0] a);
    int n = 0;
    IF_REQ = 1'b1; IF_ADDR = a;
    do begin tick(); n++; end while (!IF_GNT && n < 20);
    chk("if_gnt_latency", n, 1);
    IF_REQ = 1'b0;
    if (!IF_GNT) return;
    tick();
    chk("if_acc_rd", RD, 1);
    chk("if_acc_addr", ADDR, a);
    tick();
    chk("if_resp_valid", {IF_VALID, LS_VALID}, 2'b10);
    chk("if_resp_data", IF_DATA, ref_mem[a]);
  endtask

  int            ls_run, grants, if_cnt, bound;
  logic          if_prev, ls_prev, exp_if;
  logic [DW-1:0] if_q[$], ls_q[$];
  int            t0, t1, t2;
  logic [AW-1:0] ra;
  logic [DW-1:0] rd_val;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'(i * 40503) ^ 16'h5A3C;
      ref_mem[i] = mem[i];
    end
    mem[16'h05AA]     = 16'h0BF0;
    ref_mem[16'h05AA] = 16'h0BF0;

    // Reset with both requests asserted.
    RST = 1'b0; IF_REQ = 1'b1; LS_REQ = 1'b1; LS_WE = 1'b0;
    IF_ADDR = 16'h1234; LS_ADDR = 16'h4321; LS_WDATA = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_gnt", {IF_GNT, LS_GNT}, 2'b00);
      chk("rst_rdwr", {RD, WR}, 2'b00);
      chk("rst_addr", ADDR, 0);
      chk("rst_valid", {IF_VALID, LS_VALID}, 2'b00);
    end
    IF_REQ = 1'b0; LS_REQ = 1'b0; RST = 1'b1;
    tick();
    chk("post_rst_idle", {IF_GNT, LS_GNT, RD, WR}, 4'b0000);

    // Load, store, reload.
    do_ls(1'b0, 16'h05AA, '0);
    chk("load_const", LS_RDATA, 16'h0BF0);
    do_ls(1'b1, 16'h05AA, 16'h3EBA);
    do_ls(1'b0, 16'h05AA, '0);
    chk("reload_const", LS_RDATA, 16'h3EBA);

    // Starvation: both ports request continuously.
    IF_REQ = 1'b1; IF_ADDR = 16'($urandom);
    LS_REQ = 1'b1; LS_WE = 1'b0; LS_ADDR = 16'($urandom);
    ls_run = 0; grants = 0; if_cnt = 0; bound = 0;
    while ((IF_REQ || LS_REQ || if_q.size() != 0 || ls_q.size() != 0) && bound < 300) begin
      if_prev = IF_REQ; ls_prev = LS_REQ;
      tick(); bound++;
      if (!if_prev) ls_run = 0;
      if (IF_VALID) begin
        if (if_q.size() == 0) chk("starve_if_spurious", 1, 0);
        else chk("starve_if_data", IF_DATA, if_q.pop_front());
      end
      if (LS_VALID) begin
        if (ls_q.size() == 0) chk("starve_ls_spurious", 1, 0);
        else chk("starve_ls_data", LS_RDATA, ls_q.pop_front());
      end
      if (IF_GNT || LS_GNT) begin
        exp_if = if_prev && (!ls_prev || ls_run >= SMAX);
        chk("starve_pick", {IF_GNT, LS_GNT}, {exp_if, !exp_if});
        grants++;
        if (IF_GNT) begin
          if_q.push_back(ref_mem[IF_ADDR]);
          if_cnt++; ls_run = 0;
          IF_ADDR = 16'($urandom);
          if (grants >= 12) IF_REQ = 1'b0;
        end else begin
          ls_q.push_back(ref_mem[LS_ADDR]);
          if (if_prev && ls_run < SMAX) ls_run++;
          LS_ADDR = 16'($urandom);
          if (grants >= 12) LS_REQ = 1'b0;
        end
      end
    end
    chk("starve_done", bound < 300, 1);
    chk("starve_if_grants", if_cnt >= 3, 1);
    IF_REQ = 1'b0; LS_REQ = 1'b0;
    tick();

    // Reset asserted while the write strobe is high.
    LS_REQ = 1'b1; LS_WE = 1'b1; LS_ADDR = 16'h0333; LS_WDATA = 16'hC0DE;
    tick();
    chk("rw_gnt", LS_GNT, 1);
    LS_REQ = 1'b0;
    tick();
    tick();
    chk("rw_pulse", WR, 1);
    RST = 1'b0;
    tick();
    chk("rw_wr_off", {WR, RD}, 2'b00);
    chk("rw_no_valid", LS_VALID, 0);
    chk("rw_addr", ADDR, 0);
    RST = 1'b1;
    tick();
    chk("rw_after", {LS_VALID, WR}, 2'b00);
    ref_mem[16'h0333] = mem[16'h0333];
    do_ls(1'b0, 16'h05AA, '0);

    // Fetch stream 0,1,2 back to back.
    do_if(16'h0000); t0 = cyc;
    do_if(16'h0001); t1 = cyc;
    do_if(16'h0002); t2 = cyc;
    chk("fetch_spacing1", t1 - t0, 3);
    chk("fetch_spacing2", t2 - t1, 3);
    chk("fetch_last", IF_DATA, ref_mem[2]);

    // Address extremes.
    do_ls(1'b1, 16'hFFFF, 16'hA55A);
    do_ls(1'b0, 16'hFFFF, '0);
    chk("ffff_const", LS_RDATA, 16'hA55A);
    do_if(16'h0000);

    // Random mix over a small hot region and the full space.
    for (int k = 0; k < 40; k++) begin
      ra = ($urandom_range(0, 1) != 0) ? (16'h0100 | 16'($urandom_range(0, 7))) : 16'($urandom);
      rd_val = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       do_if(ra);
        1:       do_ls(1'b0, ra, '0);
        default: do_ls(1'b1, ra, rd_val);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
